// File: rtl/draw_sequencer_if.sv
// -----------------------------------------------------------------------------
// draw_sequencer_if
//   Handshake/bus bundle between the game FSM (master) and the draw sequencer
//   (slave).
//   master -> slave : start, sprite, abort
//   slave  -> master: addr, x_off, y_off, plot, busy, done
// -----------------------------------------------------------------------------
interface draw_sequencer_if;
    logic        start;
    logic        sprite;
    logic        abort;
    logic [14:0] addr;
    logic [7:0]  x_off;
    logic [6:0]  y_off;
    logic        plot;
    logic        busy;
    logic        done;

    modport master (
        output start, sprite, abort,
        input  addr, x_off, y_off, plot, busy, done
    );

    modport slave (
        input  start, sprite, abort,
        output addr, x_off, y_off, plot, busy, done
    );
endinterface

// File: rtl/draw_sequencer.sv
// -----------------------------------------------------------------------------
// draw_sequencer
//   Walks a full-screen (SCREEN_W x SCREEN_H) or sprite (SPRITE_W x SPRITE_H)
//   region in raster order, one ROM address per cycle. Pixel offsets and the
//   plot strobe are delayed ROM_LAT cycles so they line up with ROM data.
//   Ports:
//     clk     system clock
//     resetn  asynchronous active-low reset
//     bus     draw_sequencer_if.slave
//       start/sprite  draw request and region select (sampled in IDLE)
//       abort         cancel of an in-progress draw (LOAD/DRAW/FLUSH)
//       addr          ROM read address
//       x_off/y_off   pixel offsets, ROM-latency aligned
//       plot          VGA write enable, ROM-latency aligned
//       busy          high in LOAD, DRAW and FLUSH
//       done          one-cycle pulse on draw completion
// -----------------------------------------------------------------------------
module draw_sequencer #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int SPRITE_W = 40,
    parameter int SPRITE_H = 40,
    parameter int ROM_LAT  = 1      // legal range 1..3
) (
    input  logic              clk,
    input  logic              resetn,
    draw_sequencer_if.slave   bus
);

    localparam logic [7:0] SCR_COL_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] SCR_ROW_LAST = 7'(SCREEN_H - 1);
    localparam logic [7:0] SPR_COL_LAST = 8'(SPRITE_W - 1);
    localparam logic [6:0] SPR_ROW_LAST = 7'(SPRITE_H - 1);
    localparam logic [1:0] FLUSH_LAST   = 2'(ROM_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAW,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        mode_q, mode_d;
    logic [7:0]  col_q, col_d;
    logic [6:0]  row_q, row_d;
    logic [14:0] addr_q, addr_d;
    logic [1:0]  flush_q, flush_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Delay line carrying (valid, col, row) from issue to ROM data arrival.
    logic [ROM_LAT-1:0]      vld_q, vld_d;
    logic [ROM_LAT-1:0][7:0] x_q, x_d;
    logic [ROM_LAT-1:0][6:0] y_q, y_d;

    logic [7:0] col_last;
    logic [6:0] row_last;
    logic       abort_hit;

    assign col_last  = mode_q ? SPR_COL_LAST : SCR_COL_LAST;
    assign row_last  = mode_q ? SPR_ROW_LAST : SCR_ROW_LAST;
    assign abort_hit = bus.abort &&
                       (state_q == S_LOAD || state_q == S_DRAW || state_q == S_FLUSH);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        flush_d = flush_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d  = bus.sprite;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                col_d   = '0;
                row_d   = '0;
                addr_d  = '0;
                state_d = S_DRAW;
            end
            S_DRAW: begin
                if (col_q == col_last && row_q == row_last) begin
                    // Last pixel issued: addr holds while the ROM drains.
                    flush_d = '0;
                    state_d = S_FLUSH;
                end else begin
                    // Raster order means the linear address is simply +1.
                    addr_d = addr_q + 15'd1;
                    if (col_q == col_last) begin
                        col_d = '0;
                        row_d = row_q + 7'd1;
                    end else begin
                        col_d = col_q + 8'd1;
                    end
                end
            end
            S_FLUSH: begin
                if (flush_q == FLUSH_LAST) state_d = S_DONE;
                else                       flush_d = flush_q + 2'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort_hit) state_d = S_IDLE;

        // Abort kills every in-flight valid so nothing plots afterwards.
        vld_d[0] = (state_q == S_DRAW) && !abort_hit;
        x_d[0]   = col_q;
        y_d[0]   = row_q;
        for (int i = 1; i < ROM_LAT; i++) begin
            vld_d[i] = vld_q[i-1] && !abort_hit;
            x_d[i]   = x_q[i-1];
            y_d[i]   = y_q[i-1];
        end

        // Status flags are registered from the next state.
        busy_d = (state_d == S_LOAD) || (state_d == S_DRAW) || (state_d == S_FLUSH);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            flush_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            col_q   <= col_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            flush_q <= flush_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign bus.addr  = addr_q;
    assign bus.x_off = x_q[ROM_LAT-1];
    assign bus.y_off = y_q[ROM_LAT-1];
    assign bus.plot  = vld_q[ROM_LAT-1];
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// -----------------------------------------------------------------------------
// tb_draw_sequencer
//   Two sequencers (ROM_LAT=1 and ROM_LAT=3) receive identical stimulus. A
//   timeline model tracks, per DUT, the number of cycles since the accepted
//   start and derives every expected output from that count.
// -----------------------------------------------------------------------------
module tb_draw_sequencer;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start = 1'b0;
    logic sprite = 1'b0;
    logic abort = 1'b0;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    draw_sequencer_if bus1();
    draw_sequencer_if bus3();

    assign bus1.start  = start;
    assign bus1.sprite = sprite;
    assign bus1.abort  = abort;
    assign bus3.start  = start;
    assign bus3.sprite = sprite;
    assign bus3.abort  = abort;

    draw_sequencer #(.ROM_LAT(1)) dut1 (.clk(clk), .resetn(resetn), .bus(bus1));
    draw_sequencer #(.ROM_LAT(3)) dut3 (.clk(clk), .resetn(resetn), .bus(bus3));

    logic [32:0] obs1, obs3;
    assign obs1 = {bus1.plot, bus1.busy, bus1.done, bus1.addr, bus1.x_off, bus1.y_off};
    assign obs3 = {bus3.plot, bus3.busy, bus3.done, bus3.addr, bus3.x_off, bus3.y_off};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model (timeline per DUT) ----------------
    bit act[2]  = '{1'b0, 1'b0};
    int rel[2]  = '{0, 0};
    int mw[2]   = '{160, 160};
    int mh[2]   = '{120, 120};

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int d = 0; d < 2; d++) act[d] <= 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!act[d]) begin
                    if (start) begin
                        act[d] <= 1'b1;
                        rel[d] <= 1;
                        mw[d]  <= sprite ? 40 : 160;
                        mh[d]  <= sprite ? 40 : 120;
                    end
                end else if (abort && rel[d] <= mw[d]*mh[d] + 1 + lat_of(d)) begin
                    act[d] <= 1'b0;
                end else if (rel[d] == mw[d]*mh[d] + 2 + lat_of(d)) begin
                    act[d] <= 1'b0;
                end else begin
                    rel[d] <= rel[d] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int n, l, r, p;
            bit a, pe, ae;
            logic [32:0] o, e;
            n  = mw[d] * mh[d];
            l  = lat_of(d);
            r  = rel[d];
            a  = act[d];
            pe = a && r >= 2 + l && r <= n + 1 + l;
            ae = a && r >= 2 && r <= n + 1 + l;
            p  = pe ? r - 2 - l : 0;
            e  = {pe,
                  a && r >= 1 && r <= n + 1 + l,
                  a && r == n + 2 + l,
                  ae ? 15'((r - 2 < n - 1) ? r - 2 : n - 1) : 15'd0,
                  pe ? 8'(p % mw[d]) : 8'd0,
                  pe ? 7'(p / mw[d]) : 7'd0};
            o  = (d == 0) ? obs1 : obs3;
            o  = {o[32:30], ae ? o[29:15] : 15'd0, pe ? o[14:0] : 15'd0};
            check((d == 0) ? "cyc_lat1" : "cyc_lat3", 64'(o), 64'(e));
        end
    end

    // ---------------- stimulus ----------------
    // One draw request; noise_rel injects a stray start, abort_rel an abort,
    // rst_rel an asynchronous reset, each at that many cycles after start.
    task automatic draw(input bit spr, input bit abort_with_start,
                        input int noise_rel, input int abort_rel, input int rst_rel);
        int r;
        start  = 1'b1;
        sprite = spr;
        abort  = abort_with_start;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        r = 1;
        while ((act[0] || act[1]) && r < 25000) begin
            sprite = 1'($urandom);
            start  = (r == noise_rel);
            abort  = (r == abort_rel);
            if (r == rst_rel) begin
                resetn = 1'b0;
                #1;
                check("rst_async_lat1", 64'(obs1), 64'(0));
                check("rst_async_lat3", 64'(obs3), 64'(0));
            end
            @(posedge clk); #1;
            resetn = 1'b1;
            r++;
        end
        check("draw_timeout", 64'(r >= 25000), 64'(0));
        start = 1'b0;
        abort = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_lat1", 64'(obs1), 64'(0));
        check("reset_lat3", 64'(obs3), 64'(0));
        resetn = 1'b1;
        @(posedge clk); #1;

        draw(1'b1, 1'b0, -1, -1, -1);        // plain sprite draw
        draw(1'b1, 1'b0, 502, -1, -1);       // start at addr 500 ignored
        draw(1'b1, 1'b0, 1603, -1, -1);      // start in DONE/FLUSH ignored
        draw(1'b0, 1'b1, -1, -1, -1);        // screen draw, abort with start ignored
        draw(1'b0, 1'b0, -1, 102, -1);       // abort at addr 100
        draw(1'b1, 1'b0, -1, -1, 802);       // reset at addr 800
        check("post_reset_addr", 64'(bus1.addr), 64'(0));
        draw(1'b1, 1'b0, -1, -1, -1);        // restart after reset
        for (int k = 0; k < 3; k++) begin
            draw(1'b1, 1'($urandom), int'($urandom_range(1, 1601)),
                 ($urandom % 2) ? int'($urandom_range(1, 1605)) : -1, -1);
        end
        check("idle_busy_lat1", 64'(bus1.busy), 64'(0));
        check("idle_busy_lat3", 64'(bus3.busy), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
